// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester ports and the downstream memory port of the arbiter.
// The arbiter uses the slave view; requesters and the memory model use master.
interface mem_port_arbiter_if;
  logic        m0_request_enable;
  logic        m0_mode;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_response_enable;
  logic [31:0] m0_data;
  logic        m0_error;

  logic        m1_request_enable;
  logic        m1_mode;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_response_enable;
  logic [31:0] m1_data;
  logic        m1_error;

  logic        mem_request_enable;
  logic        mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_response_enable;
  logic [31:0] mem_data;
  logic        mem_owner;

  modport slave (
    input  m0_request_enable, m0_mode, m0_addr, m0_wdata, m0_wstrb,
    output m0_response_enable, m0_data, m0_error,
    input  m1_request_enable, m1_mode, m1_addr, m1_wdata, m1_wstrb,
    output m1_response_enable, m1_data, m1_error,
    output mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb, mem_owner,
    input  mem_response_enable, mem_data
  );

  modport master (
    output m0_request_enable, m0_mode, m0_addr, m0_wdata, m0_wstrb,
    input  m0_response_enable, m0_data, m0_error,
    output m1_request_enable, m1_mode, m1_addr, m1_wdata, m1_wstrb,
    input  m1_response_enable, m1_data, m1_error,
    input  mem_request_enable, mem_mode, mem_addr, mem_wdata, mem_wstrb, mem_owner,
    output mem_response_enable, mem_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one pulse-style memory port between two requesters, one
// transaction in flight; request pulses latched, responses routed back, optional timeout.
module mem_port_arbiter #(
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic MEMREQ_READ    = 1'b0,
  parameter logic MEMREQ_WRITE   = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;

  logic [1:0]        req, req_wr, cap, busy;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0][3:0]   req_wstrb;

  logic [1:0]        pend, is_wr;
  logic [1:0][31:0]  addr_q, wdata_q;
  logic [1:0][3:0]   wstrb_q;

  logic [1:0]        rsp_en, rsp_err;
  logic [1:0][31:0]  rsp_data;

  logic              last_grant, owner, grant, winner, done, timeout_hit;
  logic [CW-1:0]     cnt;
  logic              mreq_en, mreq_wr;
  logic [31:0]       mreq_addr, mreq_wdata;
  logic [3:0]        mreq_wstrb;

  always_comb begin
    req       = {bus.m1_request_enable, bus.m0_request_enable};
    req_wr    = {bus.m1_mode == MEMREQ_WRITE, bus.m0_mode == MEMREQ_WRITE};
    req_addr  = {bus.m1_addr, bus.m0_addr};
    req_wdata = {bus.m1_wdata, bus.m0_wdata};
    req_wstrb = {bus.m1_wstrb, bus.m0_wstrb};

    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    done        = (state == WAIT) && (bus.mem_response_enable || timeout_hit);

    // The owner may re-request on the very edge its transaction completes.
    busy = 2'b00;
    if (state == WAIT && !done) busy[owner] = 1'b1;
    cap = req & ~pend & ~busy;

    grant  = (state == IDLE) && (pend != 2'b00);
    winner = (pend == 2'b11) ? ~last_grant : pend[1];

    state_nxt = state;
    if (grant)     state_nxt = WAIT;
    else if (done) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend       <= '0;
      is_wr      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rsp_en     <= '0;
      rsp_err    <= '0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      mreq_en    <= 1'b0;
      mreq_wr    <= 1'b0;
      mreq_addr  <= '0;
      mreq_wdata <= '0;
      mreq_wstrb <= '0;
    end else begin
      mreq_en <= 1'b0;
      rsp_en  <= '0;

      for (int n = 0; n < 2; n++) begin
        if (cap[n]) begin
          pend[n]    <= 1'b1;
          is_wr[n]   <= req_wr[n];
          addr_q[n]  <= req_addr[n];
          wdata_q[n] <= req_wdata[n];
          wstrb_q[n] <= req_wstrb[n];
        end
      end

      if (grant) begin
        pend[winner] <= 1'b0;
        mreq_en      <= 1'b1;
        mreq_wr      <= is_wr[winner];
        mreq_addr    <= addr_q[winner];
        mreq_wdata   <= wdata_q[winner];
        mreq_wstrb   <= wstrb_q[winner];
        owner        <= winner;
        last_grant   <= winner;
        cnt          <= '0;
      end else if (state == WAIT) begin
        if (done) begin
          // A real response beats a coincident timeout.
          rsp_en[owner]   <= 1'b1;
          rsp_data[owner] <= bus.mem_response_enable ? bus.mem_data : 32'h0;
          rsp_err[owner]  <= ~bus.mem_response_enable;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.mem_request_enable = mreq_en;
  assign bus.mem_mode           = mreq_wr ? MEMREQ_WRITE : MEMREQ_READ;
  assign bus.mem_addr           = mreq_addr;
  assign bus.mem_wdata          = mreq_wdata;
  assign bus.mem_wstrb          = mreq_wstrb;
  assign bus.mem_owner          = owner;

  assign bus.m0_response_enable = rsp_en[0];
  assign bus.m0_data            = rsp_data[0];
  assign bus.m0_error           = rsp_err[0];
  assign bus.m1_response_enable = rsp_en[1];
  assign bus.m1_data            = rsp_data[1];
  assign bus.m1_error           = rsp_err[1];
endmodule
